alu_div_sched: RTL and testbench
================================

# alu_div_sched

Shared-divider scheduler: arbitrates up to `NUM_REQ` requesters onto the single iterative divider inside the ALU. It sequences the divider's `enable_i` / `ready_o` / `ex_ready_i` handshake for each requester. It holds each result until that requester accepts it. It short-circuits divide-by-zero without occupying the divider. It sits between the EX-stage issue logic (plus any auxiliary requester) and the ALU's DIV/REM path.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, range 2..4.
- `RID_W`, default `$clog2(NUM_REQ)`: requester index width.

Ports:
- `core_clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid_i` in `[NUM_REQ]`: request valid, one per requester.
- `req_ready_o` out `[NUM_REQ]`: request accepted this cycle.
- `req_op_i` in `[NUM_REQ]` x `alu_opcode_e`: opcode; only `ALU_DIVU`, `ALU_DIV`, `ALU_REMU`, `ALU_REM` are legal.
- `req_a_i`, `req_b_i` in `[NUM_REQ]` x 32: dividend and divisor.
- `rsp_valid_o` out `[NUM_REQ]`: result valid for that requester.
- `rsp_ready_i` in `[NUM_REQ]`: requester takes the result.
- `rsp_result_o` out 32: result, shared bus, meaningful for the requester whose `rsp_valid_o` is high.
- `rsp_err_o` out 1: illegal opcode flag, qualifies `rsp_result_o`.
- `div_enable_o` out 1: drives ALU `enable_i`.
- `div_operator_o` out `alu_opcode_e`: drives ALU `operator_i`.
- `div_a_o`, `div_b_o` out 32: drive ALU `operand_a_i` / `operand_b_i`.
- `div_ex_ready_o` out 1: drives ALU `ex_ready_i`.
- `div_ready_i` in 1: ALU `ready_o`.
- `div_result_i` in 32: ALU `result_o`.

## Operation
- The FSM has three states: `IDLE`, `BUSY`, `RESP`. Reset state is `IDLE`.
- Reset values: all `req_ready_o`=0, `rsp_valid_o`=0, `rsp_result_o`=0, `rsp_err_o`=0, `div_enable_o`=0, `div_ex_ready_o`=0. `div_operator_o`=`ALU_DIVU`, `div_a_o`=0, `div_b_o`=0. The round-robin pointer is 0.
- **IDLE**
  - Round-robin grant among the set `req_valid_i` bits, starting at the pointer.
  - `req_ready_o[g]`=1 combinationally for the granted index only.
  - On accept, latch the opcode, operands and owner id, and advance the pointer to g+1 mod `NUM_REQ`.
  - Legal opcode with `b`≠0: go to `BUSY`.
  - Divisor `b`==0: skip the divider and go to `RESP`. Result is `32'hFFFFFFFF` for DIV/DIVU and `a` for REM/REMU.
  - Illegal opcode: go to `RESP` with result 0 and `rsp_err_o`=1.
- **BUSY**
  - `div_enable_o`=1, with the operator and operands driven from the latches. They are stable for the whole operation.
  - When `div_ready_i`=1, capture `div_result_i`, pulse `div_ex_ready_o`=1 in that same cycle, and go to `RESP`.
  - `div_ex_ready_o` is 0 in every other cycle.
- **RESP**
  - `rsp_valid_o[owner]`=1, with the result and error flag from their registers.
  - When `rsp_ready_i[owner]`=1, go to `IDLE`.
  - No new request is accepted in this state.
  - Other requesters see `req_ready_o`=0 throughout `BUSY` and `RESP`.
- Signed overflow (0x80000000 / -1) is passed to the divider unchanged; the divider's result is returned.
- Requesters must hold their request fields stable while `req_valid_i`=1 and `req_ready_o`=0.

## Timing
- Accept happens at edge 0.
- Divider path: `div_enable_o` is high from cycle 1. If `div_ready_i` rises in cycle k, `rsp_valid_o` rises in cycle k+1.
- Bypass path (b==0 or illegal opcode): `rsp_valid_o` rises in cycle 1, giving 1-cycle latency.
- Back-to-back operations: after a RESP handshake at edge n, the block is back in `IDLE` in cycle n and can accept again in that same cycle. Minimum issue interval is therefore 2 cycles for the bypass path.
- Simultaneous valid requests: exactly one grant per accept, in round-robin order. A continuously asserting requester waits at most `NUM_REQ`-1 operations.
- Asserting `rst` in any state forces `IDLE` and drops `div_enable_o` immediately, which is asynchronous. The divider's own `rst_n` is driven by the core and is not controlled here.
- `rsp_ready_i` held low: the FSM stays in `RESP` indefinitely, and the result and error flag stay stable.

## Structure
- Add to `cv32e40p_pkg`:
  - an `alu_div_sched_state_e` enum for the three states;
  - the constants `DIV_ZERO_QUOT` (`32'hFFFFFFFF`) and `NUM_REQ_MAX` (4);
  - an `is_div_op()` function that checks `op[6:2]` == `5'b01100`.
- One sub-module: `rr_arbiter`, parameterized on `NUM_REQ`. Inputs are the valid vector and the pointer. Outputs are a one-hot grant and a grant index. It is combinational; the pointer register lives in the parent.
- Total RTL is about 200 lines.

## Test plan
- Unsigned divide: requester 0 sends `ALU_DIVU`, a=100, b=7. Require `div_enable_o` high until `div_ready_i`, a one-cycle `div_ex_ready_o` pulse, then `rsp_result_o`=14 on requester 0.
- Signed remainder: `ALU_REM`, a=-7 (`32'hFFFFFFF9`), b=2. Require result `32'hFFFFFFFF`. Then `ALU_DIV`, a=`32'h80000000`, b=`32'hFFFFFFFF`. Require result `32'h80000000`.
- Divide by zero: `ALU_DIV` a=5, b=0 gives `32'hFFFFFFFF` in cycle 1. `ALU_REMU` a=5, b=0 gives 5. In both cases `div_enable_o` stays 0.
- Contention: both requesters hold valid continuously with distinct operands. Require grant order 0,1,0,1, and each result routed to the correct `rsp_valid_o` bit. An illegal opcode (`ALU_ADD`) returns `rsp_err_o`=1 with result 0.
- Backpressure: hold `rsp_ready_i`=0 for 10 cycles. Require the result to stay stable and no new accept. Release it and require a return to `IDLE`, with an accept in that same cycle.
- Reset mid-BUSY: assert `rst` 3 cycles after accept. Require all outputs to reach their reset values asynchronously and the pointer to return to 0. After release, a new request completes correctly.

Source files
------------

// File: rtl/alu_div_sched_pkg.sv
// Shared types, constants and helpers for the shared-divider scheduler.
package alu_div_sched_pkg;

  // ALU opcode encoding (subset of the core's ALU operators).
  typedef enum logic [6:0] {
    ALU_AND  = 7'b0010101,
    ALU_ADD  = 7'b0011000,
    ALU_SUB  = 7'b0011001,
    ALU_OR   = 7'b0101110,
    ALU_XOR  = 7'b0101111,
    ALU_DIVU = 7'b0110000,
    ALU_DIV  = 7'b0110001,
    ALU_REMU = 7'b0110010,
    ALU_REM  = 7'b0110011
  } alu_opcode_e;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } alu_div_sched_state_e;

  // Quotient returned for a divide by zero (all ones).
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
  // Largest supported requester count.
  localparam int NUM_REQ_MAX = 4;

  // True for DIVU/DIV/REMU/REM.
  function automatic logic is_div_op(input alu_opcode_e op);
    return (op[6:2] == 5'b01100);
  endfunction

  // Within the divide group, bit 1 selects remainder over quotient.
  function automatic logic is_rem_op(input alu_opcode_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/alu_div_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches valid_i starting at ptr_i and
// returns the first set index as a one-hot grant and as a binary index.
// The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int RID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [RID_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [RID_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o
);

  logic [RID_W:0] idx;

  // Rotating priority search: first valid at or after the pointer wins.
  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    idx         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr_i} + (RID_W + 1)'(i);
      if (idx >= (RID_W + 1)'(NUM_REQ)) begin
        idx = idx - (RID_W + 1)'(NUM_REQ);
      end
      if (!gnt_valid_o && valid_i[idx[RID_W-1:0]]) begin
        gnt_valid_o                = 1'b1;
        gnt_idx_o                  = idx[RID_W-1:0];
        gnt_o[idx[RID_W-1:0]]      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_div_sched.sv
// Shared-divider scheduler: arbitrates NUM_REQ requesters onto the ALU's
// single iterative divider, holds each result until its owner takes it, and
// answers divide-by-zero and illegal opcodes without touching the divider.
//
// Handshakes: a request transfers on a rising edge where req_valid_i[i] and
// req_ready_o[i] are both high; a response transfers on a rising edge where
// rsp_valid_o[i] and rsp_ready_i[i] are both high. Requesters keep their
// fields stable while valid is high and ready is low. Toward the divider,
// div_enable_o stays high with stable operands until div_ready_i, and
// div_ex_ready_o pulses in that same cycle to release the divider.
module alu_div_sched
  import alu_div_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int RID_W   = $clog2(NUM_REQ)
) (
  input  logic                 core_clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  alu_opcode_e          req_op_i [NUM_REQ],
  input  logic [31:0]          req_a_i  [NUM_REQ],
  input  logic [31:0]          req_b_i  [NUM_REQ],
  output logic [NUM_REQ-1:0]   rsp_valid_o,
  input  logic [NUM_REQ-1:0]   rsp_ready_i,
  output logic [31:0]          rsp_result_o,
  output logic                 rsp_err_o,
  output logic                 div_enable_o,
  output alu_opcode_e          div_operator_o,
  output logic [31:0]          div_a_o,
  output logic [31:0]          div_b_o,
  output logic                 div_ex_ready_o,
  input  logic                 div_ready_i,
  input  logic [31:0]          div_result_i,
  output alu_div_sched_state_e dbg_state_o
);

  alu_div_sched_state_e state_q, state_d;
  logic [RID_W-1:0]     ptr_q, ptr_d;
  logic [RID_W-1:0]     owner_q, owner_d;
  alu_opcode_e          op_q, op_d;
  logic [31:0]          a_q, a_d;
  logic [31:0]          b_q, b_d;
  logic [31:0]          res_q, res_d;
  logic                 err_q, err_d;

  logic [NUM_REQ-1:0]   gnt_oh;
  logic [RID_W-1:0]     gnt_idx;
  logic                 gnt_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .RID_W   (RID_W)
  ) u_arb (
    .valid_i     (req_valid_i),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt_oh),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  // Divider interface and response bus come straight from registers so they
  // stay stable for the whole operation. Signed overflow (0x80000000 / -1)
  // is passed through untouched; the divider defines that result.
  assign div_enable_o   = (state_q == BUSY);
  assign div_operator_o = op_q;
  assign div_a_o        = a_q;
  assign div_b_o        = b_q;
  assign rsp_result_o   = res_q;
  assign rsp_err_o      = err_q;
  assign dbg_state_o    = state_q;

  // Next-state, latch updates and handshake outputs.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    owner_d        = owner_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    res_d          = res_q;
    err_d          = err_q;
    req_ready_o    = '0;
    rsp_valid_o    = '0;
    div_ex_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          req_ready_o = gnt_oh;
          owner_d     = gnt_idx;
          op_d        = req_op_i[gnt_idx];
          a_d         = req_a_i[gnt_idx];
          b_d         = req_b_i[gnt_idx];
          ptr_d       = (gnt_idx == RID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + RID_W'(1);
          if (!is_div_op(req_op_i[gnt_idx])) begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else if (req_b_i[gnt_idx] == '0) begin
            // Divide by zero is answered locally; the divider stays idle.
            res_d   = is_rem_op(req_op_i[gnt_idx]) ? req_a_i[gnt_idx] : DIV_ZERO_QUOT;
            err_d   = 1'b0;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (div_ready_i) begin
          res_d          = div_result_i;
          div_ex_ready_o = 1'b1;
          state_d        = RESP;
        end
      end
      RESP: begin
        rsp_valid_o[owner_q] = 1'b1;
        if (rsp_ready_i[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latch registers; reset drops div_enable_o immediately.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      op_q    <= ALU_DIVU;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_div_sched.sv
// Directed bench for alu_div_sched with two requesters. The bench plays the
// role of the iterative divider, answering after a chosen number of cycles.
module tb_alu_div_sched;
  import alu_div_sched_pkg::*;

  localparam int NR = 2;

  // ---------------- clock / reset ----------------
  logic core_clk = 1'b0;
  logic rst;
  always #5 core_clk = ~core_clk;

  logic [NR-1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
  alu_opcode_e          req_op [NR];
  logic [31:0]          req_a  [NR];
  logic [31:0]          req_b  [NR];
  logic [31:0]          rsp_result;
  logic                 rsp_err;
  logic                 div_enable;
  alu_opcode_e          div_operator;
  logic [31:0]          div_a, div_b;
  logic                 div_ex_ready;
  logic                 div_ready;
  logic [31:0]          div_result;
  alu_div_sched_state_e dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  // observations filled by drive_op
  int            o_acc_wait, o_en, o_exr, o_lat, o_bad_opnd;
  logic [NR-1:0] o_rv;
  logic [31:0]   o_res;
  logic          o_err;

  logic [31:0] exp_q[$];

  alu_div_sched #(.NUM_REQ(NR)) dut (
    .core_clk       (core_clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_op_i       (req_op),
    .req_a_i        (req_a),
    .req_b_i        (req_b),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_result_o   (rsp_result),
    .rsp_err_o      (rsp_err),
    .div_enable_o   (div_enable),
    .div_operator_o (div_operator),
    .div_a_o        (div_a),
    .div_b_o        (div_b),
    .div_ex_ready_o (div_ex_ready),
    .div_ready_i    (div_ready),
    .div_result_i   (div_result),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge core_clk);
    #1;
  endtask

  // Issue one operation on requester r, act as the divider (ready after `lat`
  // enable cycles, returning `res`), record what was seen, then take the result.
  task automatic drive_op(input int r, input alu_opcode_e op, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] res);
    o_acc_wait = 0; o_en = 0; o_exr = 0; o_lat = -1; o_bad_opnd = 0;
    o_rv = '0; o_res = '0; o_err = 1'b0;
    cyc();
    req_op[r] = op; req_a[r] = a; req_b[r] = b; req_valid[r] = 1'b1;
    #1;
    while (!req_ready[r] && o_acc_wait < 50) begin
      cyc();
      o_acc_wait++;
    end
    if (!req_ready[r]) begin
      req_valid[r] = 1'b0;
      o_acc_wait = -1;
      return;
    end
    @(posedge core_clk);
    cyc();
    req_valid[r] = 1'b0;
    #1;
    for (int t = 1; t <= 100; t++) begin
      if (rsp_valid != '0) begin
        o_lat = t; o_rv = rsp_valid; o_res = rsp_result; o_err = rsp_err;
        break;
      end
      if (div_enable) begin
        o_en++;
        if (div_a !== a || div_b !== b || div_operator !== op) o_bad_opnd++;
        if (o_en == lat) begin
          div_ready = 1'b1; div_result = res;
          #1;
        end
      end
      if (div_ex_ready) o_exr++;
      cyc();
      div_ready = 1'b0; div_result = '0;
      #1;
    end
    if (o_lat < 0) return;
    rsp_ready[r] = 1'b1;
    @(posedge core_clk);
    cyc();
    rsp_ready[r] = 1'b0;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_cmp++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    n_cmp++; if (rsp_result !== 32'h0) begin n_bad++; $display("FAIL reset_rsp_result got=%h exp=0", rsp_result); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    n_cmp++; if (div_enable !== 1'b0) begin n_bad++; $display("FAIL reset_div_enable got=%b exp=0", div_enable); end
    n_cmp++; if (div_ex_ready !== 1'b0) begin n_bad++; $display("FAIL reset_div_ex_ready got=%b exp=0", div_ex_ready); end
    n_cmp++; if (div_operator !== ALU_DIVU) begin n_bad++; $display("FAIL reset_div_operator got=%h exp=%h", div_operator, ALU_DIVU); end
    n_cmp++; if (div_a !== 32'h0) begin n_bad++; $display("FAIL reset_div_a got=%h exp=0", div_a); end
    n_cmp++; if (div_b !== 32'h0) begin n_bad++; $display("FAIL reset_div_b got=%h exp=0", div_b); end
  endtask

  task automatic test_divu();
    drive_op(0, ALU_DIVU, 32'd100, 32'd7, 3, 32'd14);
    n_cmp++; if (o_acc_wait !== 0) begin n_bad++; $display("FAIL divu_accept_wait got=%0d exp=0", o_acc_wait); end
    n_cmp++; if (o_en !== 3) begin n_bad++; $display("FAIL divu_enable_cycles got=%0d exp=3", o_en); end
    n_cmp++; if (o_exr !== 1) begin n_bad++; $display("FAIL divu_ex_ready_pulses got=%0d exp=1", o_exr); end
    n_cmp++; if (o_lat !== 4) begin n_bad++; $display("FAIL divu_rsp_latency got=%0d exp=4", o_lat); end
    n_cmp++; if (o_rv !== 2'b01) begin n_bad++; $display("FAIL divu_rsp_valid got=%b exp=01", o_rv); end
    n_cmp++; if (o_res !== 32'd14) begin n_bad++; $display("FAIL divu_result got=%h exp=%h", o_res, 32'd14); end
    n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL divu_err got=%b exp=0", o_err); end
    n_cmp++; if (o_bad_opnd !== 0) begin n_bad++; $display("FAIL divu_operand_stable got=%0d exp=0", o_bad_opnd); end
    n_cmp++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL divu_back_idle got=%0d exp=%0d", dbg_state, IDLE); end
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL divu_rsp_dropped got=%b exp=00", rsp_valid); end
  endtask

  task automatic test_signed();
    drive_op(1, ALU_REM, 32'hFFFF_FFF9, 32'd2, 2, 32'hFFFF_FFFF);
    n_cmp++; if (o_res !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rem_result got=%h exp=ffffffff", o_res); end
    n_cmp++; if (o_rv !== 2'b10) begin n_bad++; $display("FAIL rem_rsp_valid got=%b exp=10", o_rv); end
    n_cmp++; if (o_lat !== 3) begin n_bad++; $display("FAIL rem_rsp_latency got=%0d exp=3", o_lat); end
    n_cmp++; if (o_bad_opnd !== 0) begin n_bad++; $display("FAIL rem_operand_stable got=%0d exp=0", o_bad_opnd); end
    drive_op(0, ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5, 32'h8000_0000);
    n_cmp++; if (o_res !== 32'h8000_0000) begin n_bad++; $display("FAIL ovf_result got=%h exp=80000000", o_res); end
    n_cmp++; if (o_rv !== 2'b01) begin n_bad++; $display("FAIL ovf_rsp_valid got=%b exp=01", o_rv); end
    n_cmp++; if (o_en !== 5) begin n_bad++; $display("FAIL ovf_enable_cycles got=%0d exp=5", o_en); end
    n_cmp++; if (o_lat !== 6) begin n_bad++; $display("FAIL ovf_rsp_latency got=%0d exp=6", o_lat); end
    n_cmp++; if (o_bad_opnd !== 0) begin n_bad++; $display("FAIL ovf_operand_stable got=%0d exp=0", o_bad_opnd); end
  endtask

  task automatic test_div_zero();
    drive_op(0, ALU_DIV, 32'd5, 32'd0, 1, 32'hDEAD_BEEF);
    n_cmp++; if (o_lat !== 1) begin n_bad++; $display("FAIL dz_div_latency got=%0d exp=1", o_lat); end
    n_cmp++; if (o_en !== 0) begin n_bad++; $display("FAIL dz_div_enable_cycles got=%0d exp=0", o_en); end
    n_cmp++; if (o_res !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dz_div_result got=%h exp=ffffffff", o_res); end
    n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL dz_div_err got=%b exp=0", o_err); end
    n_cmp++; if (o_exr !== 0) begin n_bad++; $display("FAIL dz_div_ex_ready got=%0d exp=0", o_exr); end
    drive_op(1, ALU_REMU, 32'd5, 32'd0, 1, 32'hDEAD_BEEF);
    n_cmp++; if (o_lat !== 1) begin n_bad++; $display("FAIL dz_remu_latency got=%0d exp=1", o_lat); end
    n_cmp++; if (o_en !== 0) begin n_bad++; $display("FAIL dz_remu_enable_cycles got=%0d exp=0", o_en); end
    n_cmp++; if (o_res !== 32'd5) begin n_bad++; $display("FAIL dz_remu_result got=%h exp=5", o_res); end
    n_cmp++; if (o_rv !== 2'b10) begin n_bad++; $display("FAIL dz_remu_rsp_valid got=%b exp=10", o_rv); end
  endtask

  task automatic test_illegal();
    drive_op(0, ALU_ADD, 32'd3, 32'd4, 1, 32'hDEAD_BEEF);
    n_cmp++; if (o_lat !== 1) begin n_bad++; $display("FAIL ill_latency got=%0d exp=1", o_lat); end
    n_cmp++; if (o_en !== 0) begin n_bad++; $display("FAIL ill_enable_cycles got=%0d exp=0", o_en); end
    n_cmp++; if (o_res !== 32'h0) begin n_bad++; $display("FAIL ill_result got=%h exp=0", o_res); end
    n_cmp++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL ill_err got=%b exp=1", o_err); end
    n_cmp++; if (o_rv !== 2'b01) begin n_bad++; $display("FAIL ill_rsp_valid got=%b exp=01", o_rv); end
  endtask

  // Both requesters hold valid; grants must alternate 0,1,0,1.
  task automatic test_contention();
    logic [31:0] ca [4];
    logic [31:0] cb [4];
    logic [31:0] cr [4];
    logic [1:0]  exp_gnt;
    logic [31:0] exp_res;
    int          own;
    ca = '{32'd40, 32'd21, 32'd90, 32'd64};
    cb = '{32'd5,  32'd3,  32'd9,  32'd8};
    cr = '{32'd8,  32'd7,  32'd10, 32'd8};
    cyc(); rst = 1'b1; #1;
    cyc(); rst = 1'b0; #1;
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(cr[k]);
    req_op[0] = ALU_DIVU; req_a[0] = ca[0]; req_b[0] = cb[0];
    req_op[1] = ALU_DIVU; req_a[1] = ca[1]; req_b[1] = cb[1];
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      own = k % 2;
      exp_gnt = 2'b01 << own;
      n_cmp++; if (req_ready !== exp_gnt) begin n_bad++; $display("FAIL cont_grant_%0d got=%b exp=%b", k, req_ready, exp_gnt); end
      @(posedge core_clk);
      cyc();
      if (k + 2 < 4) begin
        req_a[own] = ca[k+2]; req_b[own] = cb[k+2];
      end else begin
        req_valid[own] = 1'b0;
      end
      #1;
      n_cmp++; if ({div_enable, div_a, div_b} !== {1'b1, ca[k], cb[k]}) begin n_bad++; $display("FAIL cont_div_issue_%0d got=%b/%h/%h exp=1/%h/%h", k, div_enable, div_a, div_b, ca[k], cb[k]); end
      div_ready = 1'b1; div_result = cr[k];
      @(posedge core_clk);
      cyc();
      div_ready = 1'b0; div_result = '0;
      #1;
      exp_res = exp_q.pop_front();
      n_cmp++; if (rsp_valid !== exp_gnt) begin n_bad++; $display("FAIL cont_rsp_valid_%0d got=%b exp=%b", k, rsp_valid, exp_gnt); end
      n_cmp++; if (rsp_result !== exp_res) begin n_bad++; $display("FAIL cont_result_%0d got=%h exp=%h", k, rsp_result, exp_res); end
      rsp_ready = exp_gnt;
      #1;
      n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL cont_no_accept_in_resp_%0d got=%b exp=00", k, req_ready); end
      @(posedge core_clk);
      cyc();
      rsp_ready = '0;
      #1;
    end
  endtask

  task automatic test_backpressure();
    cyc();
    req_op[0] = ALU_DIV; req_a[0] = 32'd5; req_b[0] = 32'd0; req_valid[0] = 1'b1;
    #1;
    @(posedge core_clk);
    cyc();
    req_valid[0] = 1'b0;
    req_op[1] = ALU_DIVU; req_a[1] = 32'd50; req_b[1] = 32'd5; req_valid[1] = 1'b1;
    #1;
    for (int c = 0; c < 10; c++) begin
      n_cmp++; if ({rsp_valid, rsp_result, rsp_err, req_ready} !== {2'b01, 32'hFFFF_FFFF, 1'b0, 2'b00}) begin n_bad++; $display("FAIL bp_hold_%0d got=%b/%h/%b/%b exp=01/ffffffff/0/00", c, rsp_valid, rsp_result, rsp_err, req_ready); end
      cyc();
    end
    rsp_ready[0] = 1'b1;
    #1;
    @(posedge core_clk);
    cyc();
    rsp_ready[0] = 1'b0;
    #1;
    n_cmp++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL bp_back_idle got=%0d exp=%0d", dbg_state, IDLE); end
    n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL bp_same_cycle_accept got=%b exp=10", req_ready); end
    @(posedge core_clk);
    cyc();
    req_valid[1] = 1'b0;
    #1;
    n_cmp++; if ({div_enable, div_a} !== {1'b1, 32'd50}) begin n_bad++; $display("FAIL bp_next_issue got=%b/%h exp=1/00000032", div_enable, div_a); end
    div_ready = 1'b1; div_result = 32'd10;
    @(posedge core_clk);
    cyc();
    div_ready = 1'b0; div_result = '0;
    #1;
    n_cmp++; if ({rsp_valid, rsp_result} !== {2'b10, 32'd10}) begin n_bad++; $display("FAIL bp_next_result got=%b/%h exp=10/0000000a", rsp_valid, rsp_result); end
    rsp_ready[1] = 1'b1;
    @(posedge core_clk);
    cyc();
    rsp_ready[1] = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid_busy();
    // accept on requester 0 so the pointer moves to 1 before reset
    cyc();
    req_op[0] = ALU_DIVU; req_a[0] = 32'd100; req_b[0] = 32'd7; req_valid[0] = 1'b1;
    #1;
    @(posedge core_clk);
    cyc();
    req_valid[0] = 1'b0;
    #1;
    cyc();
    cyc();
    n_cmp++; if (div_enable !== 1'b1) begin n_bad++; $display("FAIL rmb_busy_before got=%b exp=1", div_enable); end
    rst = 1'b1;
    #1;
    n_cmp++; if (div_enable !== 1'b0) begin n_bad++; $display("FAIL rmb_enable_async got=%b exp=0", div_enable); end
    n_cmp++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL rmb_state got=%0d exp=%0d", dbg_state, IDLE); end
    n_cmp++; if ({rsp_valid, req_ready, div_ex_ready, rsp_err} !== 6'b0) begin n_bad++; $display("FAIL rmb_handshakes got=%b/%b/%b/%b exp=00/00/0/0", rsp_valid, req_ready, div_ex_ready, rsp_err); end
    n_cmp++; if ({rsp_result, div_a, div_b} !== 96'h0) begin n_bad++; $display("FAIL rmb_data got=%h/%h/%h exp=0/0/0", rsp_result, div_a, div_b); end
    n_cmp++; if (div_operator !== ALU_DIVU) begin n_bad++; $display("FAIL rmb_operator got=%h exp=%h", div_operator, ALU_DIVU); end
    cyc();
    rst = 1'b0;
    req_op[0] = ALU_DIVU; req_a[0] = 32'd56; req_b[0] = 32'd8;
    req_op[1] = ALU_DIVU; req_a[1] = 32'd9;  req_b[1] = 32'd3;
    req_valid = 2'b11;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rmb_pointer_reset got=%b exp=01", req_ready); end
    req_valid = 2'b00;
    #1;
    drive_op(0, ALU_DIVU, 32'd56, 32'd8, 2, 32'd7);
    n_cmp++; if (o_res !== 32'd7) begin n_bad++; $display("FAIL rmb_after_result got=%h exp=7", o_res); end
    n_cmp++; if (o_rv !== 2'b01) begin n_bad++; $display("FAIL rmb_after_rsp_valid got=%b exp=01", o_rv); end
    n_cmp++; if (o_lat !== 3) begin n_bad++; $display("FAIL rmb_after_latency got=%0d exp=3", o_lat); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    req_valid = '0; rsp_ready = '0; div_ready = 1'b0; div_result = '0;
    for (int i = 0; i < NR; i++) begin
      req_op[i] = ALU_DIVU; req_a[i] = '0; req_b[i] = '0;
    end
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    test_reset();
    test_divu();
    test_signed();
    test_div_zero();
    test_illegal();
    test_contention();
    test_backpressure();
    test_reset_mid_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard bound on simulated time.
  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
